// File: rtl/pb_event_arbiter.sv
// Round-robin serialiser for debounced pushbutton press pulses.
// Each channel latches one pending press; pending channels are presented one
// at a time on a valid/ready event port. Presses that arrive while the
// channel is still pending are counted in a saturating drop counter.
module pb_event_arbiter #(
  parameter int N_BTN = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] pulse_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [N_BTN-1:0] pending,
  output logic [CNTW-1:0]  drop_cnt,
  input  logic             clr_drop
);

  localparam int PCW  = $clog2(N_BTN + 1);
  localparam int SUMW = CNTW + PCW;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e           state_q;
  logic             evt_valid_q;
  logic [IDW-1:0]   evt_id_q;
  logic [IDW-1:0]   rr_q;
  logic [N_BTN-1:0] pending_q;
  logic [N_BTN-1:0] pending_d;
  logic [CNTW-1:0]  drop_q;
  logic [CNTW-1:0]  drop_d;

  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] drop_vec;
  logic             gnt_found;
  logic             gnt_en;
  logic [IDW-1:0]   gnt_idx;
  logic [PCW-1:0]   n_drop;
  logic [SUMW-1:0]  drop_sum;

  // Round-robin pick on registered pending: first set bit above rr, else wrap from 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!gnt_found && pending_q[i] && (i > int'(rr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (!gnt_found && pending_q[i] && (i <= int'(rr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
  end

  // A grant may load the output register when it is empty or being consumed.
  assign gnt_en = gnt_found && ((state_q == S_IDLE) || evt_ready);

  // Per-channel latch update: a new press always wins over the grant clear.
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    assign grant_vec[gi] = gnt_en && (gnt_idx == IDW'(gi));
    assign drop_vec[gi]  = pulse_in[gi] & pending_q[gi] & ~grant_vec[gi];
    assign pending_d[gi] = pulse_in[gi] | (pending_q[gi] & ~grant_vec[gi]);
  end

  // Saturating drop count; a clear in the same cycle keeps only this cycle's drops.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_BTN; i++) begin
      n_drop = n_drop + PCW'(drop_vec[i]);
    end
    drop_sum = {{PCW{1'b0}}, (clr_drop ? {CNTW{1'b0}} : drop_q)} + {{CNTW{1'b0}}, n_drop};
    if (drop_sum > {{PCW{1'b0}}, {CNTW{1'b1}}}) begin
      drop_d = {CNTW{1'b1}};
    end else begin
      drop_d = drop_sum[CNTW-1:0];
    end
  end

  // Pending latches and drop counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  // Output FSM: IDLE waits for any pending channel, HOLD presents one event until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_q        <= IDW'(N_BTN - 1);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_en) begin
            state_q     <= S_HOLD;
            evt_valid_q <= 1'b1;
            evt_id_q    <= gnt_idx;
            rr_q        <= gnt_idx;
          end
        end
        S_HOLD: begin
          if (evt_ready) begin
            if (gnt_en) begin
              evt_id_q <= gnt_idx;
              rr_q     <= gnt_idx;
            end else begin
              state_q     <= S_IDLE;
              evt_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Self-checking bench for pb_event_arbiter: directed scenarios push expected
// event ids into a queue, a monitor pops them on every accepted event.
module tb_pb_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] pulse_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic [7:0] drop_cnt;
  logic       clr_drop;

  int n_cmp;
  int n_mis;
  int exp_q[$];

  pb_event_arbiter #(.N_BTN(4), .IDW(2), .CNTW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .pending  (pending),
    .drop_cnt (drop_cnt),
    .clr_drop (clr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    pulse_in = v;
    tick();
    pulse_in = 4'b0000;
  endtask

  // Scoreboard monitor: every accepted event must match the oldest expected id.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_evt", int'(evt_id), -1);
      end else begin
        $display("accept evt_id=%0d expected=%0d", evt_id, exp_q[0]);
        check_eq("sb_evt_id", int'(evt_id), exp_q.pop_front());
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    rst_n     = 1'b0;
    pulse_in  = 4'b0000;
    evt_ready = 1'b0;
    clr_drop  = 1'b0;
    repeat (3) tick();
    #3 rst_n = 1'b1;
    tick();

    // Reset state
    check_eq("rst_valid", int'(evt_valid), 0);
    check_eq("rst_id", int'(evt_id), 0);
    check_eq("rst_pending", int'(pending), 0);
    check_eq("rst_drop", int'(drop_cnt), 0);

    // 1: single press, two-edge latency, one-cycle event
    evt_ready = 1'b1;
    exp_q.push_back(2);
    pulse(4'b0100);
    check_eq("t1_pending", int'(pending), 4'b0100);
    check_eq("t1_valid_early", int'(evt_valid), 0);
    tick();
    check_eq("t1_valid", int'(evt_valid), 1);
    check_eq("t1_id", int'(evt_id), 2);
    check_eq("t1_pending_clr", int'(pending), 0);
    tick();
    check_eq("t1_valid_end", int'(evt_valid), 0);
    check_eq("t1_sb_empty", exp_q.size(), 0);

    // 2: all four pressed, served 0..3 back to back (rr was at 2 -> starts at 3? no: reset rr only
    // applies before first grant; here rr=2 so order is 3,0,1,2)
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    pulse(4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_valid", int'(evt_valid), 1);
      check_eq("t2_id", int'(evt_id), (i + 3) % 4);
    end
    tick();
    check_eq("t2_valid_end", int'(evt_valid), 0);
    check_eq("t2_drop", int'(drop_cnt), 0);
    check_eq("t2_sb_empty", exp_q.size(), 0);

    // 3: back-pressure, id held, re-press latches, third press drops
    evt_ready = 1'b0;
    pulse(4'b0001);
    tick();
    check_eq("t3_valid", int'(evt_valid), 1);
    check_eq("t3_id", int'(evt_id), 0);
    check_eq("t3_pending0", int'(pending), 0);
    tick();
    pulse(4'b0001);
    tick();
    check_eq("t3_id_stable", int'(evt_id), 0);
    check_eq("t3_pending1", int'(pending), 4'b0001);
    pulse(4'b0001);
    check_eq("t3_drop", int'(drop_cnt), 1);
    exp_q.push_back(0); exp_q.push_back(0);
    evt_ready = 1'b1;
    tick();
    tick();
    check_eq("t3_valid_end", int'(evt_valid), 0);
    check_eq("t3_sb_empty", exp_q.size(), 0);
    clr_drop = 1'b1;
    tick();
    clr_drop = 1'b0;
    check_eq("t3_drop_clr", int'(drop_cnt), 0);

    // 4: round-robin wrap: after granting 2 with 0101 pending -> 0 then 2
    evt_ready = 1'b0;
    pulse(4'b0100);
    pulse(4'b0101);
    check_eq("t4_id_held", int'(evt_id), 2);
    check_eq("t4_pending", int'(pending), 4'b0101);
    exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
    evt_ready = 1'b1;
    tick();
    check_eq("t4_id_wrap", int'(evt_id), 0);
    tick();
    check_eq("t4_id_next", int'(evt_id), 2);
    tick();
    check_eq("t4_valid_end", int'(evt_valid), 0);
    check_eq("t4_sb_empty", exp_q.size(), 0);

    // 5a: same-cycle grant and re-press of channel 1
    exp_q.push_back(1); exp_q.push_back(1);
    pulse_in = 4'b0010;
    tick();
    tick();
    pulse_in = 4'b0000;
    check_eq("t5_pending_kept", int'(pending), 4'b0010);
    check_eq("t5_drop_none", int'(drop_cnt), 0);
    tick();
    tick();
    check_eq("t5_valid_end", int'(evt_valid), 0);
    check_eq("t5_sb_empty", exp_q.size(), 0);

    // 5b: drops, clear with simultaneous drop, popcount, saturation
    evt_ready = 1'b0;
    pulse(4'b1000);
    pulse(4'b1000);
    pulse(4'b1000);
    pulse(4'b1000);
    check_eq("t5_drop2", int'(drop_cnt), 2);
    clr_drop = 1'b1;
    pulse(4'b1000);
    clr_drop = 1'b0;
    check_eq("t5_clr_with_drop", int'(drop_cnt), 1);
    clr_drop = 1'b1;
    tick();
    clr_drop = 1'b0;
    pulse(4'b1111);
    check_eq("t5_drop_one", int'(drop_cnt), 1);
    pulse(4'b1111);
    check_eq("t5_drop_popcnt", int'(drop_cnt), 5);
    for (int i = 0; i < 300; i++) pulse(4'b1000);
    check_eq("t5_drop_sat", int'(drop_cnt), 255);
    check_eq("t5_id_held", int'(evt_id), 3);

    // 6: async reset mid-operation, then index 0 priority
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_async_drop", int'(drop_cnt), 0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    pulse(4'b0010);
    pulse(4'b1010);
    pulse(4'b0010);
    check_eq("t6_pre_valid", int'(evt_valid), 1);
    check_eq("t6_pre_pending", int'(pending), 4'b1010);
    check_eq("t6_pre_drop", int'(drop_cnt), 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_valid", int'(evt_valid), 0);
    check_eq("t6_id", int'(evt_id), 0);
    check_eq("t6_pending", int'(pending), 0);
    check_eq("t6_drop", int'(drop_cnt), 0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    evt_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(2);
    pulse(4'b0101);
    tick();
    check_eq("t6_first_id", int'(evt_id), 0);
    tick();
    tick();
    check_eq("t6_valid_end", int'(evt_valid), 0);
    check_eq("t6_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
